// File: rtl/vga_fb_arbiter_pkg.sv
// Shared framebuffer geometry and arbiter grant encoding.
package vga_fb_arbiter_pkg;

  localparam int FB_AW     = 15;
  localparam int FB_DW     = 3;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_t;

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// Posted-write queue: DEPTH x W FIFO, head visible combinationally, zero-latency pop.
// Pushes while full and pops while empty are ignored; full is count based.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head_dat,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == FULL_CNT);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads always win, drawing writes are
// posted into a small queue and drained in video-idle cycles. Read latency 2 cycles.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int WQ_DEPTH   = 4,
  parameter int STARVE_MAX = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vid_req,
  input  logic [AW-1:0] i_vid_addr,
  output logic          o_vid_valid,
  output logic [DW-1:0] o_vid_data,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wq_empty,
  output logic          o_wq_starve,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  grant_t                    w_grant;
  logic [AW+DW-1:0]          w_head;
  logic                      w_full;
  logic [$clog2(WQ_DEPTH):0] w_count;
  logic                      w_push;
  logic                      w_pop;
  logic [SW-1:0]             w_starve_nxt;

  logic                      r_rd_pend;
  logic                      r_vid_valid;
  logic [DW-1:0]             r_vid_data;
  logic [SW-1:0]             r_starve_cnt;
  logic                      r_starve;

  assign o_wq_empty  = (w_count == '0);
  assign o_wr_ready  = !w_full;
  assign w_push      = i_wr_valid && !w_full;
  assign w_pop       = (w_grant == GNT_WRITE);
  assign o_vid_valid = r_vid_valid;
  assign o_vid_data  = r_vid_data;
  assign o_wq_starve = r_starve;

  fb_wr_fifo #(
    .DEPTH (WQ_DEPTH),
    .W     (AW + DW)
  ) u_wq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat ({i_wr_addr, i_wr_data}),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_count    (w_count)
  );

  always_comb begin
    w_grant     = GNT_IDLE;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_vid_req) begin
      w_grant    = GNT_READ;
      o_mem_en   = 1'b1;
      o_mem_addr = i_vid_addr;
    end else if (!o_wq_empty) begin
      w_grant     = GNT_WRITE;
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = w_head[AW+DW-1:DW];
      o_mem_wdata = w_head[DW-1:0];
    end
  end

  // RAM data arrives the cycle after issue; register it once more for the pixel path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_rd_pend   <= (w_grant == GNT_READ);
      r_vid_valid <= r_rd_pend;
      if (r_rd_pend) r_vid_data <= i_mem_rdata;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (o_wq_empty || w_grant != GNT_READ)
      w_starve_nxt = '0;
    else if (r_starve_cnt != STARVE_LIM)
      w_starve_nxt = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_starve     <= r_starve || (w_starve_nxt == STARVE_LIM);
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized and directed bench for vga_fb_arbiter against a queue-based model.
module tb_vga_fb_arbiter;
  localparam int AW = 15;
  localparam int DW = 3;
  localparam int DEPTH = 4;
  localparam int SMAX = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wq_empty;
  logic          wq_starve;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #20 clk = ~clk;

  vga_fb_arbiter #(.AW(AW), .DW(DW), .WQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr),
    .o_vid_valid(vid_valid), .o_vid_data(vid_data),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wq_empty(wq_empty), .o_wq_starve(wq_starve),
    .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Framebuffer RAM seen by the DUT
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: picture contents, pending writes, expected pixels
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  wr_t           mq[$];
  rd_t           rq[$];
  logic [DW-1:0] m_last = '0;
  int            m_starve_cnt = 0;
  bit            m_starve = 1'b0;
  int            cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance model.
  task automatic step(input logic vr, input logic [AW-1:0] va,
                      input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit            ne, full, exp_en, exp_we, exp_v;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    wr_t           w;
    @(negedge clk);
    vid_req = vr; vid_addr = va; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1;
    ne       = (mq.size() != 0);
    full     = (mq.size() >= DEPTH);
    exp_en   = vr || ne;
    exp_we   = !vr && ne;
    exp_addr = vr ? va : (ne ? mq[0].a : '0);
    exp_wd   = exp_we ? mq[0].d : '0;
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
    chk("wr_ready", 32'(wr_ready), 32'(!full));
    chk("wq_empty", 32'(wq_empty), 32'(!ne));
    chk("wq_starve", 32'(wq_starve), 32'(m_starve));
    exp_v = (rq.size() != 0) && (rq[0].due == cyc);
    if (exp_v) m_last = rq.pop_front().d;
    chk("vid_valid", 32'(vid_valid), 32'(exp_v));
    chk("vid_data", 32'(vid_data), 32'(m_last));
    if (vr) begin
      rq.push_back('{due: cyc + 2, d: ref_mem[va]});
    end else if (ne) begin
      w = mq.pop_front();
      ref_mem[w.a] = w.d;
    end
    if (ne && vr) m_starve_cnt = (m_starve_cnt < SMAX) ? m_starve_cnt + 1 : SMAX;
    else          m_starve_cnt = 0;
    if (m_starve_cnt == SMAX) m_starve = 1'b1;
    if (wv && !full) mq.push_back('{a: wa, d: wd});
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vid_req = 1'b0; wr_valid = 1'b0;
    vid_addr = '0; wr_addr = '0; wr_data = '0;
    #1;
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_vid_data", 32'(vid_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_wq_empty", 32'(wq_empty), 32'd1);
    chk("rst_wq_starve", 32'(wq_starve), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    mq.delete(); rq.delete();
    m_last = '0; m_starve_cnt = 0; m_starve = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Registered outputs only, just after the edge that closes the last stepped cycle
  task automatic post_edge(input string tag, input logic [31:0] got_sel, input logic [31:0] exp);
    chk(tag, got_sel, exp);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[5] = 3'b101; ref_mem[5] = 3'b101;

    // reset, including mid-stream with reads in flight
    do_reset();
    idle(2);
    step(1'b1, 15'h0001, 1'b1, 15'h0100, 3'd6);
    step(1'b1, 15'h0002, 1'b1, 15'h0101, 3'd7);
    do_reset();
    idle(4);

    // video only: fixed two-cycle latency, then back-to-back stream
    step(1'b1, 15'h0005, 1'b0, '0, '0);
    @(posedge clk); #1;
    post_edge("lat_t1_valid", 32'(vid_valid), 32'd0);
    step(1'b0, '0, 1'b0, '0, '0);
    @(posedge clk); #1;
    post_edge("lat_t2_valid", 32'(vid_valid), 32'd1);
    post_edge("lat_t2_data", 32'(vid_data), 32'd5);
    for (int i = 0; i < 100; i++) step(1'b1, AW'(i * 37), 1'b0, '0, '0);
    idle(3);

    // write drain with video idle
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, AW'(16 + i), DW'(i + 1));
    idle(3);
    @(posedge clk); #1;
    post_edge("drain_empty", 32'(wq_empty), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, AW'(16 + i), 1'b0, '0, '0);
    idle(3);

    // contention: queue fills behind reads, fifth write held until space frees
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 1'b1, AW'(32 + i), DW'(i + 3));
    @(posedge clk); #1;
    post_edge("full_ready", 32'(wr_ready), 32'd0);
    step(1'b0, '0, 1'b1, 15'h0024, 3'd2);
    step(1'b0, '0, 1'b1, 15'h0024, 3'd2);
    idle(6);
    step(1'b1, 15'h0024, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, AW'(32 + i), 1'b0, '0, '0);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
    idle(4);

    // starvation: sticky flag after exactly SMAX denied cycles
    do_reset();
    idle(1);
    step(1'b1, 15'h0000, 1'b1, 15'h0200, 3'd1);
    for (int i = 0; i < SMAX - 1; i++) step(1'b1, AW'(i), 1'b0, '0, '0);
    @(posedge clk); #1;
    post_edge("starve_early", 32'(wq_starve), 32'd0);
    step(1'b1, 15'h0010, 1'b0, '0, '0);
    @(posedge clk); #1;
    post_edge("starve_set", 32'(wq_starve), 32'd1);
    idle(6);
    @(posedge clk); #1;
    post_edge("starve_sticky", 32'(wq_starve), 32'd1);
    post_edge("starve_drained", 32'(wq_empty), 32'd1);
    do_reset();
    idle(2);

    // frame-style scan-out with draws confined to horizontal blanking
    for (int line = 0; line < 8; line++) begin
      for (int x = 0; x < 800; x++) begin
        if (x < 640)
          step(1'b1, AW'((line * 15) * 160 + x / 4), 1'b0, '0, '0);
        else
          step(1'b0, '0, 1'($urandom), AW'($urandom_range(0, 19199)), DW'($urandom));
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
